sound_unpack: RTL and testbench

//  Upstream feeder for the sound FIFO stage. On a command, reads one audio block of

---
 rtl/sound_unpack_pkg.sv | 9 +
 rtl/sound_unpack_if.sv | 25 ++
 rtl/sound_unpack_lane_sel.sv | 16 +
 rtl/sound_unpack.sv | 92 +++++++++
 tb/tb_sound_unpack.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sound_unpack_pkg.sv
// sound_unpack_pkg: FSM states, channel codes and lane counts for sound_unpack.
package sound_unpack_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DONE} state_t;
   localparam logic [1:0] CHAN_OFF    = 2'd0;
   localparam logic [1:0] CHAN_MONO   = 2'd1;
   localparam logic [1:0] CHAN_STEREO = 2'd2;
   localparam int LANES_STEREO = 2;
   localparam int LANES_MONO   = 4;
endpackage

// File: rtl/sound_unpack_if.sv
// sound_unpack_if: command, DDR read and sound frame signals of sound_unpack.
interface sound_unpack_if #(parameter int AW = 29, parameter int BW = 16);
   logic          cmd_start;
   logic [AW-1:0] cmd_addr;
   logic [BW-1:0] cmd_bytes;
   logic [1:0]    sound_chan;
   logic          ddr_rd_req;
   logic [AW-1:0] ddr_rd_addr;
   logic          ddr_rd_valid;
   logic [63:0]   ddr_rd_data;
   logic          sound_write_ready;
   logic          sound_write;
   logic [15:0]   sound_l;
   logic [15:0]   sound_r;
   logic          busy;
   logic          done;
   modport master (
      input  cmd_start, cmd_addr, cmd_bytes, sound_chan, ddr_rd_valid, ddr_rd_data, sound_write_ready,
      output ddr_rd_req, ddr_rd_addr, sound_write, sound_l, sound_r, busy, done
   );
   modport slave (
      output cmd_start, cmd_addr, cmd_bytes, sound_chan, ddr_rd_valid, ddr_rd_data, sound_write_ready,
      input  ddr_rd_req, ddr_rd_addr, sound_write, sound_l, sound_r, busy, done
   );
endinterface

// File: rtl/sound_unpack_lane_sel.sv
// sound_lane_sel: picks the left/right samples of one frame out of a 64-bit PCM word.
module sound_lane_sel (
   input  logic [63:0] word,
   input  logic [1:0]  lane,
   input  logic        mono,
   output logic [15:0] l,
   output logic [15:0] r
);
   logic [2:0]  idx;
   logic [63:0] sh;
   // stereo frames occupy two 16-bit lanes, mono frames one
   assign idx = mono ? {1'b0, lane} : {lane[0], 1'b0, 1'b0} >> 1 | {1'b0, lane[0], 1'b0};
   assign sh  = word >> {idx, 4'b0};
   assign l   = sh[15:0];
   assign r   = mono ? sh[15:0] : sh[31:16];
endmodule

// File: rtl/sound_unpack.sv
// sound_unpack: fetches a PCM block from DDR and emits mono/stereo frames downstream.
// Optional SOUND_UNPACK_STATS_EN adds saturating frame and stall counters.
module sound_unpack
   import sound_unpack_pkg::*;
#(
   parameter int AW = 29,
   parameter int BW = 16
) (
   input  logic clk_sys,
   input  logic reset_n,
   sound_unpack_if.master bus
`ifdef SOUND_UNPACK_STATS_EN
   ,
   output logic [31:0] stat_frames,
   output logic [31:0] stat_stall
`endif
);
   state_t        state, state_nx;
   logic [AW-1:0] addr;
   logic [BW-1:0] frames;
   logic [1:0]    lane;
   logic          stereo;
   logic [63:0]   word;
   logic          fire;
   logic          last_lane;

   assign fire      = state == EMIT && bus.sound_write_ready;
   assign last_lane = stereo ? lane == 2'(LANES_STEREO - 1) : lane == 2'(LANES_MONO - 1);

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx        = state;
      bus.ddr_rd_req  = 1'b0;
      bus.ddr_rd_addr = addr;
      bus.sound_write = fire;
      bus.busy        = state == REQ || state == WAIT || state == EMIT;
      bus.done        = state == DONE;
      case (state)
         IDLE:    state_nx = bus.cmd_start ? REQ : IDLE;
         REQ: begin
            bus.ddr_rd_req = frames != '0;
            state_nx       = frames == '0 ? DONE : WAIT;
         end
         WAIT:    state_nx = bus.ddr_rd_valid ? EMIT : WAIT;
         EMIT:    state_nx = !fire ? EMIT : frames == BW'(1) ? DONE : last_lane ? REQ : EMIT;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         addr   <= '0;
         frames <= '0;
         lane   <= '0;
         stereo <= 1'b0;
         word   <= '0;
      end else if (state == IDLE && bus.cmd_start) begin
         addr   <= bus.cmd_addr;
         frames <= bus.sound_chan == CHAN_OFF ? '0 : bus.sound_chan[1] ? bus.cmd_bytes >> 2 : bus.cmd_bytes >> 1;
         stereo <= bus.sound_chan[1];
         lane   <= '0;
      end else if (state == WAIT && bus.ddr_rd_valid) begin
         word <= bus.ddr_rd_data;
         lane <= '0;
      end else if (fire) begin
         frames <= frames - BW'(1);
         lane   <= last_lane ? 2'd0 : lane + 2'd1;
         addr   <= last_lane ? addr + AW'(1) : addr;
      end

   sound_lane_sel u_lane_sel (
      .word (word),
      .lane (lane),
      .mono (!stereo),
      .l    (bus.sound_l),
      .r    (bus.sound_r)
   );

`ifdef SOUND_UNPACK_STATS_EN
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         stat_frames <= '0;
         stat_stall  <= '0;
      end else begin
         if (fire && ~&stat_frames) stat_frames <= stat_frames + 32'd1;
         if (state == EMIT && !bus.sound_write_ready && ~&stat_stall) stat_stall <= stat_stall + 32'd1;
      end
`endif
endmodule

// File: tb/tb_sound_unpack.sv
// tb_sound_unpack: directed scoreboard bench for sound_unpack with a 1-cycle DDR model.
module tb_sound_unpack;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_sys = ~clk_sys;

   sound_unpack_if #(.AW(29), .BW(16)) bus ();
`ifdef SOUND_UNPACK_STATS_EN
   logic [31:0] stat_frames, stat_stall;
`endif

   sound_unpack #(.AW(29), .BW(16)) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef SOUND_UNPACK_STATS_EN
      ,
      .stat_frames (stat_frames),
      .stat_stall  (stat_stall)
`endif
   );

   int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0, reads = 0, start_cyc = 0;
   logic [31:0] exp_q[$];
   logic [28:0] exp_addr[$];
   logic [63:0] mem[logic [28:0]];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   // monitor: frames against the scoreboard, done pulses recorded
   always @(negedge clk_sys) begin
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.sound_write) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got %h_%h expected none", bus.sound_l, bus.sound_r);
         end else check("frame", 64'({bus.sound_l, bus.sound_r}), 64'(exp_q.pop_front()));
      end
   end

   // DDR model: one-cycle read latency
   initial forever begin
      @(negedge clk_sys);
      if (bus.ddr_rd_req) begin
         logic [28:0] a;
         a = bus.ddr_rd_addr;
         reads++;
         if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read got %0h expected none", a);
         end else check("rd_addr", 64'(a), 64'(exp_addr.pop_front()));
         @(posedge clk_sys);
         #1 bus.ddr_rd_valid = 1'b1;
         bus.ddr_rd_data = mem.exists(a) ? mem[a] : 64'h0;
         @(posedge clk_sys);
         #1 bus.ddr_rd_valid = 1'b0;
      end
   end

   task automatic pulse(input logic [1:0] chan, input logic [28:0] addr, input logic [15:0] bytes);
      @(posedge clk_sys);
      #1 bus.cmd_start = 1'b1;
      bus.sound_chan = chan;
      bus.cmd_addr = addr;
      bus.cmd_bytes = bytes;
      start_cyc = cyc;
      @(posedge clk_sys);
      #1 bus.cmd_start = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 500) begin
         @(posedge clk_sys);
         n++;
      end
      check("done_seen", 64'(done_cnt != d0), 64'd1);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.ddr_rd_valid && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      check("valid_seen", 64'(bus.ddr_rd_valid), 64'd1);
   endtask

   task automatic run_cmd(input logic [1:0] chan, input logic [28:0] addr, input logic [15:0] bytes, input int nreads);
      int d0, r0;
      d0 = done_cnt;
      r0 = reads;
      pulse(chan, addr, bytes);
      wait_done(d0);
      @(posedge clk_sys);
      #1 check("busy_after_done", 64'(bus.busy), 64'd0);
      check("reads", 64'(reads - r0), 64'(nreads));
      check("frames_left", 64'(exp_q.size()), 64'd0);
      check("addr_left", 64'(exp_addr.size()), 64'd0);
   endtask

   initial begin
      int d0, r0;
      bus.cmd_start = 1'b0;
      bus.cmd_addr = '0;
      bus.cmd_bytes = '0;
      bus.sound_chan = '0;
      bus.ddr_rd_valid = 1'b0;
      bus.ddr_rd_data = '0;
      bus.sound_write_ready = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1 check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_req", 64'(bus.ddr_rd_req), 64'd0);
      check("rst_write", 64'(bus.sound_write), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_lr", 64'({bus.sound_l, bus.sound_r}), 64'd0);
      check("rst_addr", 64'(bus.ddr_rd_addr), 64'd0);
      reset_n = 1'b1;

      mem[100] = 64'h4444_3333_2222_1111;
      mem[101] = 64'h8888_7777_6666_5555;
      exp_addr.push_back(100); exp_addr.push_back(101);
      exp_q.push_back(32'h1111_2222); exp_q.push_back(32'h3333_4444);
      exp_q.push_back(32'h5555_6666); exp_q.push_back(32'h7777_8888);
      run_cmd(2'd2, 29'd100, 16'd16, 2);

      mem[300] = 64'h0D0D_0C0C_0B0B_0A0A;
      exp_addr.push_back(300);
      exp_q.push_back(32'h0A0A_0A0A); exp_q.push_back(32'h0B0B_0B0B); exp_q.push_back(32'h0C0C_0C0C);
      run_cmd(2'd1, 29'd300, 16'd6, 1);

      mem[400] = 64'h0000_0000_BBBB_AAAA;
      exp_addr.push_back(400);
      exp_q.push_back(32'hAAAA_BBBB);
      run_cmd(2'd3, 29'd400, 16'd7, 1);

      run_cmd(2'd2, 29'd410, 16'd3, 0);
      check("short_done_latency", 64'(done_cyc - start_cyc), 64'd2);
      run_cmd(2'd0, 29'd420, 16'd16, 0);
      check("off_done_latency", 64'(done_cyc - start_cyc), 64'd2);

      // ready pattern 1,0,0,1 across the first EMIT cycles
      mem[500] = 64'h0004_0003_0002_0001;
      exp_addr.push_back(500);
      exp_q.push_back(32'h0001_0001); exp_q.push_back(32'h0002_0002);
      exp_q.push_back(32'h0003_0003); exp_q.push_back(32'h0004_0004);
      bus.sound_write_ready = 1'b0;
      d0 = done_cnt;
      pulse(2'd1, 29'd500, 16'd8);
      wait_valid();
      @(posedge clk_sys);
      #1 bus.sound_write_ready = 1'b1;
      @(posedge clk_sys);
      #1 bus.sound_write_ready = 1'b0;
      check("stall_l", 64'(bus.sound_l), 64'h0002);
      @(posedge clk_sys);
      #1 check("stall_hold", 64'({bus.sound_l, bus.sound_r}), 64'h0002_0002);
      check("stall_nowrite", 64'(bus.sound_write), 64'd0);
      @(posedge clk_sys);
      #1 bus.sound_write_ready = 1'b1;
      wait_done(d0);
      check("stall_frames_left", 64'(exp_q.size()), 64'd0);
`ifdef SOUND_UNPACK_STATS_EN
      check("stat_stall", 64'(stat_stall), 64'd2);
      check("stat_frames", 64'(stat_frames), 64'd12);
`endif

      // asynchronous reset while stalled in EMIT
      mem[600] = 64'h1234_5678_9ABC_DEF0;
      exp_addr.push_back(600);
      bus.sound_write_ready = 1'b0;
      d0 = done_cnt;
      pulse(2'd2, 29'd600, 16'd16);
      wait_valid();
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1 check("emit_busy", 64'(bus.busy), 64'd1);
      check("emit_l", 64'(bus.sound_l), 64'hDEF0);
      #2 reset_n = 1'b0;
      #1 check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_lr", 64'({bus.sound_l, bus.sound_r}), 64'd0);
      check("abort_req", 64'(bus.ddr_rd_req), 64'd0);
      check("abort_write", 64'(bus.sound_write), 64'd0);
      bus.sound_write_ready = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk_sys);
      check("abort_no_done", 64'(done_cnt), 64'(d0));
      check("abort_addr_left", 64'(exp_addr.size()), 64'd0);

      mem[700] = 64'h0000_0000_0000_1234;
      exp_addr.push_back(700);
      exp_q.push_back(32'h1234_1234);
      run_cmd(2'd1, 29'd700, 16'd2, 1);
`ifdef SOUND_UNPACK_STATS_EN
      check("stat_frames_after_rst", 64'(stat_frames), 64'd1);
      check("stat_stall_after_rst", 64'(stat_stall), 64'd0);
`endif

      // second cmd_start while busy must be ignored
      mem[800] = 64'h4444_3333_2222_1111;
      mem[900] = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_addr.push_back(800);
      exp_q.push_back(32'h1111_2222); exp_q.push_back(32'h3333_4444);
      d0 = done_cnt;
      r0 = reads;
      pulse(2'd2, 29'd800, 16'd8);
      pulse(2'd1, 29'd900, 16'd16);
      wait_done(d0);
      repeat (8) @(posedge clk_sys);
      check("busy_cmd_reads", 64'(reads - r0), 64'd1);
      check("busy_cmd_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("busy_cmd_frames_left", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
